// File: rtl/qarma_round_engine.sv
// QARMAv2-128 iterative round datapath: N_ROUNDS forward or inverse rounds,
// UNROLL rounds per clock, tweakeys fetched from an external schedule.
module qarma_sub_cells (
  input  logic [127:0] x_i,
  output logic [127:0] y_o
);
  function automatic logic [3:0] sbox(input logic [3:0] v);
    logic [3:0] r;
    case (v)
      4'h0: r = 4'h4;
      4'h1: r = 4'h7;
      4'h2: r = 4'h9;
      4'h3: r = 4'hb;
      4'h4: r = 4'hc;
      4'h5: r = 4'h6;
      4'h6: r = 4'he;
      4'h7: r = 4'hf;
      4'h8: r = 4'h0;
      4'h9: r = 4'h5;
      4'ha: r = 4'h1;
      4'hb: r = 4'hd;
      4'hc: r = 4'h8;
      4'hd: r = 4'h3;
      4'he: r = 4'h2;
      default: r = 4'ha;
    endcase
    return r;
  endfunction

  for (genvar i = 0; i < 32; i++) begin : g_cell
    assign y_o[4*i +: 4] = sbox(x_i[4*i +: 4]);
  end
endmodule

module qarma_inv_sub_cells (
  input  logic [127:0] x_i,
  output logic [127:0] y_o
);
  function automatic logic [3:0] isbox(input logic [3:0] v);
    logic [3:0] r;
    case (v)
      4'h0: r = 4'h8;
      4'h1: r = 4'ha;
      4'h2: r = 4'he;
      4'h3: r = 4'hd;
      4'h4: r = 4'h0;
      4'h5: r = 4'h9;
      4'h6: r = 4'h5;
      4'h7: r = 4'h1;
      4'h8: r = 4'hc;
      4'h9: r = 4'h2;
      4'ha: r = 4'hf;
      4'hb: r = 4'h3;
      4'hc: r = 4'h4;
      4'hd: r = 4'hb;
      4'he: r = 4'h6;
      default: r = 4'h7;
    endcase
    return r;
  endfunction

  for (genvar i = 0; i < 32; i++) begin : g_cell
    assign y_o[4*i +: 4] = isbox(x_i[4*i +: 4]);
  end
endmodule

module qarma_shuffle_cells (
  input  logic [127:0] x_i,
  output logic [127:0] y_o
);
  // Output cell i takes input cell (13*i+5) mod 32.
  for (genvar i = 0; i < 32; i++) begin : g_cell
    localparam int P = (13 * i + 5) % 32;
    assign y_o[4*i +: 4] = x_i[4*P +: 4];
  end
endmodule

module qarma_inv_shuffle_cells (
  input  logic [127:0] x_i,
  output logic [127:0] y_o
);
  for (genvar i = 0; i < 32; i++) begin : g_cell
    localparam int P = (13 * i + 5) % 32;
    assign y_o[4*P +: 4] = x_i[4*i +: 4];
  end
endmodule

module qarma_mix_columns (
  input  logic [127:0] x_i,
  output logic [127:0] y_o
);
  // circ(0, rho, rho^2, rho) per 4-cell column; the matrix is an involution.
  function automatic logic [3:0] rho(input logic [3:0] v);
    return {v[2:0], v[3]};
  endfunction

  function automatic logic [3:0] rho2(input logic [3:0] v);
    return {v[1:0], v[3:2]};
  endfunction

  for (genvar c = 0; c < 8; c++) begin : g_col
    for (genvar i = 0; i < 4; i++) begin : g_row
      localparam int A = 4 * c + (i + 1) % 4;
      localparam int B = 4 * c + (i + 2) % 4;
      localparam int C = 4 * c + (i + 3) % 4;
      assign y_o[4*(4*c+i) +: 4] = rho(x_i[4*A +: 4])
                                 ^ rho2(x_i[4*B +: 4])
                                 ^ rho(x_i[4*C +: 4]);
    end
  end
endmodule

module qarma_round_engine #(
  parameter int unsigned N_ROUNDS = 9,
  parameter int unsigned UNROLL   = 1,
  parameter int unsigned IDX_W    = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [127:0]              in_data,
  input  logic                      in_inv,
  output logic [UNROLL*IDX_W-1:0]   tk_idx,
  input  logic [UNROLL*128-1:0]     tk_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [127:0]              out_data,
  output logic                      busy
);
  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  localparam logic [IDX_W-1:0] LAST = IDX_W'(N_ROUNDS - 1);
  localparam logic [IDX_W-1:0] STEP = IDX_W'(UNROLL);
  localparam logic [IDX_W-1:0] NR   = IDX_W'(N_ROUNDS);

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        cnt_q, cnt_d;
  logic                    inv_q, inv_d;
  logic [127:0]            x_q, x_d;
  logic [127:0]            out_q, out_d;
  logic [UNROLL:0][127:0]  chain;
  logic [UNROLL*IDX_W-1:0] idx_run;

  assign chain[0] = x_q;

  for (genvar j = 0; j < UNROLL; j++) begin : g_slot
    logic [IDX_W-1:0] pos;
    logic [127:0]     tk;
    logic [127:0]     f_sh, f_mc, f_sb;
    logic [127:0]     i_sb, i_mc, i_sh;

    assign pos = cnt_q + IDX_W'(j);
    assign idx_run[j*IDX_W +: IDX_W] = inv_q ? LAST - pos : pos;
    assign tk = tk_data[j*128 +: 128];

    qarma_shuffle_cells u_f_sh (.x_i(tk ^ chain[j]), .y_o(f_sh));
    qarma_mix_columns   u_f_mc (.x_i(f_sh), .y_o(f_mc));
    qarma_sub_cells     u_f_sb (.x_i(f_mc), .y_o(f_sb));

    qarma_inv_sub_cells     u_i_sb (.x_i(chain[j]), .y_o(i_sb));
    qarma_mix_columns       u_i_mc (.x_i(i_sb), .y_o(i_mc));
    qarma_inv_shuffle_cells u_i_sh (.x_i(i_mc), .y_o(i_sh));

    assign chain[j+1] = inv_q ? (tk ^ i_sh) : f_sb;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      inv_q   <= 1'b0;
      x_q     <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      inv_q   <= inv_d;
      x_q     <= x_d;
      out_q   <= out_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    inv_d   = inv_q;
    x_d     = x_q;
    out_d   = out_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          x_d     = in_data;
          inv_d   = in_inv;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        x_d   = chain[UNROLL];
        cnt_d = cnt_q + STEP;
        if (cnt_d == NR) begin
          out_d   = chain[UNROLL];
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign in_ready  = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign out_data  = out_q;
  assign tk_idx    = (state_q == S_RUN) ? idx_run : '0;
endmodule

// File: tb/tb_qarma_round_engine.sv
// Bench for qarma_round_engine: UNROLL=1 and UNROLL=3 instances checked
// every cycle against a whole-operation reference model.
module tb_qarma_round_engine;
  localparam int N = 9;
  localparam int W = 5;
  localparam int U [2] = '{1, 3};
  localparam int L [2] = '{9, 3};
  localparam logic [3:0] SB [16] = '{
    4'h4, 4'h7, 4'h9, 4'hb, 4'hc, 4'h6, 4'he, 4'hf,
    4'h0, 4'h5, 4'h1, 4'hd, 4'h8, 4'h3, 4'h2, 4'ha};
  localparam logic [127:0] RT = 128'h0123456789ABCDEFFEDCBA9876543210;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         iv [2];
  logic         ii [2];
  logic [127:0] id [2];
  logic         ordy [2];
  logic         ir [2];
  logic         ov [2];
  logic [127:0] od [2];
  logic         by [2];
  logic [W-1:0]   idx0;
  logic [3*W-1:0] idx1;
  logic [127:0]   td0;
  logic [383:0]   td1;
  logic [127:0]   tk [32];

  assign td0 = tk[idx0];
  assign td1 = {tk[idx1[14:10]], tk[idx1[9:5]], tk[idx1[4:0]]};

  qarma_round_engine #(.N_ROUNDS(N), .UNROLL(1), .IDX_W(W)) u_dut0 (
    .clk(clk), .rst(rst),
    .in_valid(iv[0]), .in_ready(ir[0]), .in_data(id[0]), .in_inv(ii[0]),
    .tk_idx(idx0), .tk_data(td0),
    .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(od[0]), .busy(by[0]));

  qarma_round_engine #(.N_ROUNDS(N), .UNROLL(3), .IDX_W(W)) u_dut1 (
    .clk(clk), .rst(rst),
    .in_valid(iv[1]), .in_ready(ir[1]), .in_data(id[1]), .in_inv(ii[1]),
    .tk_idx(idx1), .tk_data(td1),
    .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(od[1]), .busy(by[1]));

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [127:0] got,
                     input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
    end
  endtask

  // ---- reference model: cells as nibble arrays, rounds as plain loops ----
  function automatic logic [3:0] isb(input logic [3:0] v);
    logic [3:0] r = 4'h0;
    for (int k = 0; k < 16; k++)
      if (SB[k] == v) r = 4'(k);
    return r;
  endfunction

  function automatic logic [3:0] rot(input logic [3:0] v, input int n);
    logic [3:0] r = v;
    for (int k = 0; k < n; k++) r = {r[2:0], r[3]};
    return r;
  endfunction

  function automatic int perm(input int i);
    return (13 * i + 5) % 32;
  endfunction

  function automatic logic [127:0] mix(input logic [127:0] x);
    logic [127:0] y;
    for (int c = 0; c < 8; c++)
      for (int i = 0; i < 4; i++)
        y[4*(4*c+i) +: 4] = rot(x[4*(4*c+(i+1)%4) +: 4], 1)
                          ^ rot(x[4*(4*c+(i+2)%4) +: 4], 2)
                          ^ rot(x[4*(4*c+(i+3)%4) +: 4], 1);
    return y;
  endfunction

  function automatic logic [127:0] fwd_round(input logic [127:0] x,
                                             input logic [127:0] k);
    logic [127:0] a, s, m, o;
    a = x ^ k;
    for (int i = 0; i < 32; i++) s[4*i +: 4] = a[4*perm(i) +: 4];
    m = mix(s);
    for (int i = 0; i < 32; i++) o[4*i +: 4] = SB[m[4*i +: 4]];
    return o;
  endfunction

  function automatic logic [127:0] inv_round(input logic [127:0] x,
                                             input logic [127:0] k);
    logic [127:0] a, m, s;
    for (int i = 0; i < 32; i++) a[4*i +: 4] = isb(x[4*i +: 4]);
    m = mix(a);
    for (int i = 0; i < 32; i++) s[4*perm(i) +: 4] = m[4*i +: 4];
    return s ^ k;
  endfunction

  function automatic logic [127:0] model_op(input logic [127:0] x,
                                            input logic inv);
    logic [127:0] r = x;
    for (int k = 0; k < N; k++)
      r = inv ? inv_round(r, tk[N-1-k]) : fwd_round(r, tk[k]);
    return r;
  endfunction

  // ---- protocol model: 0 idle, 1 run, 2 done ----
  int           ph [2] = '{0, 0};
  int           rc [2] = '{0, 0};
  logic         opinv [2];
  logic [127:0] res [2];
  logic [127:0] eo [2];
  bit           ek [2] = '{1'b0, 1'b0};

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        ph[d] <= 0;
        rc[d] <= 0;
        eo[d] <= '0;
        ek[d] <= 1'b1;
      end else if (ph[d] == 0) begin
        if (iv[d]) begin
          ph[d]    <= 1;
          rc[d]    <= 0;
          opinv[d] <= ii[d];
          res[d]   <= model_op(id[d], ii[d]);
        end
      end else if (ph[d] == 1) begin
        rc[d] <= rc[d] + 1;
        if (rc[d] + 1 == L[d]) begin
          ph[d] <= 2;
          eo[d] <= res[d];
          ek[d] <= 1'b1;
        end
      end else if (ordy[d]) begin
        ph[d] <= 0;
        ek[d] <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int d = 0; d < 2; d++) begin
        logic [14:0] e;
        logic [14:0] g;
        int p;
        e = '0;
        if (ph[d] == 1)
          for (int j = 0; j < U[d]; j++) begin
            p = rc[d] * U[d] + j;
            e[j*W +: W] = opinv[d] ? W'(N - 1 - p) : W'(p);
          end
        g = (d == 0) ? {10'b0, idx0} : idx1;
        chk($sformatf("d%0d_in_ready", d), ir[d], ph[d] == 0);
        chk($sformatf("d%0d_busy", d), by[d], ph[d] != 0);
        chk($sformatf("d%0d_out_valid", d), ov[d], ph[d] == 2);
        chk($sformatf("d%0d_tk_idx", d), g, e);
        if (ek[d]) chk($sformatf("d%0d_out_data", d), od[d], eo[d]);
      end
    end
  end

  task automatic run_op(input int d, input logic [127:0] x, input logic inv,
                        output logic [127:0] y, output int lat);
    iv[d] = 1'b1;
    id[d] = x;
    ii[d] = inv;
    @(negedge clk);
    iv[d] = 1'b0;
    lat = 0;
    while (!ov[d] && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    y = od[d];
    @(negedge clk);
  endtask

  task automatic rand_tk();
    for (int r = 0; r < 32; r++)
      tk[r] = {$urandom, $urandom, $urandom, $urandom};
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] y, z;
    int lat;
    int last [2];
    int nr [2];
    bit pv [2];

    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      iv[d] = 0; ii[d] = 0; id[d] = '0; ordy[d] = 1;
    end
    for (int r = 0; r < 32; r++) tk[r] = '0;

    chk("pin_r1", fwd_round('0, '0), {32{4'h4}});
    chk("pin_r2", fwd_round({32{4'h4}}, '0), {32{4'h7}});
    chk("pin_inv", inv_round({32{4'h4}}, '0), '0);

    @(negedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // forward op, one round per cycle: index walk and latency
    rand_tk();
    iv[0] = 1; id[0] = {$urandom, $urandom, $urandom, $urandom}; ii[0] = 0;
    @(negedge clk);
    iv[0] = 0;
    for (int k = 0; k < 9; k++) begin
      chk("t1_idx", idx0, k);
      chk("t1_nvalid", ov[0], 0);
      @(negedge clk);
    end
    chk("t1_valid", ov[0], 1);
    @(negedge clk);

    // inverse op, three rounds per cycle
    iv[1] = 1; id[1] = {$urandom, $urandom, $urandom, $urandom}; ii[1] = 1;
    @(negedge clk);
    iv[1] = 0;
    chk("t2_idx0", idx1, {5'd6, 5'd7, 5'd8});
    @(negedge clk);
    chk("t2_idx1", idx1, {5'd3, 5'd4, 5'd5});
    @(negedge clk);
    chk("t2_idx2", idx1, {5'd0, 5'd1, 5'd2});
    chk("t2_nvalid", ov[1], 0);
    @(negedge clk);
    chk("t2_valid", ov[1], 1);
    @(negedge clk);

    // forward then inverse with the same schedule restores the input
    for (int s = 0; s < 2; s++) begin
      for (int r = 0; r < 32; r++) tk[r] = (s == 0) ? '0 : {16{8'(r)}};
      for (int d = 0; d < 2; d++) begin
        run_op(d, RT, 1'b0, y, lat);
        chk("rt_fwd_lat", lat, L[d]);
        run_op(d, y, 1'b1, z, lat);
        chk("rt_inv_lat", lat, L[d]);
        chk("rt_result", z, RT);
      end
    end

    // backpressure in DONE with a request waiting
    rand_tk();
    ordy[0] = 0;
    iv[0] = 1; id[0] = {$urandom, $urandom, $urandom, $urandom}; ii[0] = 0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!ov[0] && lat < 40);
    chk("bp_reach_done", ov[0], 1);
    y = od[0];
    id[0] = {$urandom, $urandom, $urandom, $urandom};
    ii[0] = 1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_hold_data", od[0], y);
      chk("bp_in_ready", ir[0], 0);
      chk("bp_hold_valid", ov[0], 1);
    end
    ordy[0] = 1;
    @(negedge clk);
    chk("bp_drop_valid", ov[0], 0);
    chk("bp_idle", ir[0], 1);
    @(negedge clk);
    chk("bp_accept", by[0], 1);
    iv[0] = 0;
    repeat (12) @(negedge clk);

    // reset in RUN cycle 4 (unit 1 is parked in DONE by then)
    ordy[1] = 0;
    for (int d = 0; d < 2; d++) begin
      iv[d] = 1; id[d] = {$urandom, $urandom, $urandom, $urandom}; ii[d] = 0;
    end
    @(negedge clk);
    iv[0] = 0; iv[1] = 0;
    repeat (3) @(negedge clk);
    chk("rs_in_done", ov[1], 1);
    rst = 1;
    @(negedge clk);
    rst = 0;
    ordy[1] = 1;
    for (int d = 0; d < 2; d++) begin
      chk("rs_in_ready", ir[d], 1);
      chk("rs_busy", by[d], 0);
      chk("rs_out_valid", ov[d], 0);
      chk("rs_out_data", od[d], '0);
    end
    chk("rs_tk_idx0", idx0, 0);
    chk("rs_tk_idx1", idx1, 0);
    for (int d = 0; d < 2; d++) begin
      y = {$urandom, $urandom, $urandom, $urandom};
      run_op(d, y, 1'b1, z, lat);
      chk("rs_fresh_lat", lat, L[d]);
    end

    // back-to-back with direction flipped per operation
    for (int d = 0; d < 2; d++) begin
      iv[d] = 1; ordy[d] = 1; last[d] = -1; nr[d] = 0; pv[d] = 0;
    end
    for (int c = 0; c < 70; c++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (ov[d] && !pv[d]) begin
          if (last[d] >= 0) chk("b2b_period", c - last[d], L[d] + 2);
          last[d] = c;
          nr[d]++;
          ii[d] = ~ii[d];
          id[d] = {$urandom, $urandom, $urandom, $urandom};
        end
        pv[d] = ov[d];
      end
    end
    chk("b2b_ops0", nr[0] >= 5, 1);
    chk("b2b_ops1", nr[1] >= 10, 1);
    iv[0] = 0; iv[1] = 0;
    repeat (15) @(negedge clk);

    // random traffic, occasional reset, schedule changed only when drained
    for (int b = 0; b < 4; b++) begin
      rand_tk();
      for (int c = 0; c < 250; c++) begin
        rst = ($urandom_range(0, 63) == 0);
        for (int d = 0; d < 2; d++) begin
          iv[d] = $urandom_range(0, 1);
          ii[d] = $urandom_range(0, 1);
          id[d] = {$urandom, $urandom, $urandom, $urandom};
          ordy[d] = ($urandom_range(0, 3) != 0);
        end
        @(negedge clk);
      end
      rst = 0;
      for (int d = 0; d < 2; d++) begin
        iv[d] = 0; ordy[d] = 1;
      end
      repeat (15) @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/qarma_round_engine.md
Name: qarma_round_engine

Overview:
Iterative QARMAv2-128 round datapath that applies N_ROUNDS forward or inverse rounds to one 128-bit state per operation. It runs UNROLL rounds per clock and requests per-round tweakeys from an external key schedule through an index/data port. Operations use valid/ready handshakes on both sides. The block reuses the existing ShuffleCells, MixColumns, SubCells, InvSubCells and InvShuffleCells modules, and sits between the whitening stage and the reflector.

Parameters:
N_ROUNDS, 9, total rounds per operation; legal range 1..31.
UNROLL, 1, rounds applied per clock; must divide N_ROUNDS; legal values 1, 2, 3.
IDX_W, 5, width of a round index; must satisfy 2^IDX_W > N_ROUNDS.

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  an operation request is present
in_ready  out  1  the engine accepts a request this cycle
in_data  in  128  input state
in_inv  in  1  0 = forward rounds, 1 = inverse rounds
tk_idx  out  UNROLL*IDX_W  round indices requested this cycle; slot j sits at bits [j*IDX_W +: IDX_W]
tk_data  in  UNROLL*128  tweakeys for the requested indices, returned in the same cycle (combinational lookup); slot j at [j*128 +: 128]
out_valid  out  1  result is available
out_ready  in  1  the consumer accepts the result
out_data  out  128  result state
busy  out  1  high in RUN or DONE

Behaviour:
- Clock is clk. Reset is synchronous and active-high on rst.
- Reset values: state machine in IDLE, in_ready=1, out_valid=0, busy=0, out_data=0, tk_idx=0, round counter=0.
- Forward round r: x' = SubCells(MixColumns(ShuffleCells(tk[r] ^ x))).
- Inverse round r: x' = tk[r] ^ InvShuffleCells(MixColumns(InvSubCells(x))).
- Forward operations visit indices 0,1,…,N_ROUNDS-1. Inverse operations visit N_ROUNDS-1 down to 0.
- Within one cycle, slot j is applied after slot j-1. Slot j carries the j-th index of that cycle's sequence.
- State machine:
  - IDLE: in_ready=1. When in_valid=1, latch in_data and in_inv, set the counter to 0, go to RUN.
  - RUN: in_ready=0. Each cycle, apply UNROLL rounds using the tk_data sampled that cycle. Increment the counter by UNROLL. When the counter reaches N_ROUNDS, register the result into out_data, set out_valid=1 and go to DONE.
  - DONE: hold out_data and out_valid stable until out_ready=1. On the handshake edge, clear out_valid and return to IDLE.
- Latency: exactly N_ROUNDS/UNROLL RUN cycles. out_valid rises on the edge that ends the last RUN cycle.
- No request overlap: a request arriving while out_valid is high waits, because in_ready=0 in DONE.
- tk_idx is driven combinationally from the counter and the latched direction in RUN. It is 0 in IDLE and DONE. tk_data is ignored outside RUN.
- Counter arithmetic: the counter is IDX_W wide. Inverse slot index = N_ROUNDS-1-(counter+j). The counter never wraps, because RUN exits at N_ROUNDS.
- rst asserted in any state, including mid-RUN or DONE with out_ready=0: the in-flight operation is discarded, all reset values are restored on that edge, and no out_valid pulse occurs.
- in_inv, in_data and tk_data values outside their sampling cycles have no effect.

Test Plan:
- Latency and index sequence: N_ROUNDS=9, UNROLL=1, forward op → tk_idx goes 0..8 on consecutive cycles; out_valid rises 9 cycles after the acceptance edge; out_data matches the golden model bit-exactly.
- Inverse ordering with UNROLL=3: inverse op → tk_idx slots show (8,7,6), (5,4,3), (2,1,0); out_valid after 3 RUN cycles.
- Round-trip: all-zero tk schedule, then tk[r]=r replicated to 128 bits, in_data=0x0123456789ABCDEFFEDCBA9876543210 → forward then inverse with the same schedule returns 0x0123456789ABCDEFFEDCBA9876543210.
- Backpressure: hold out_ready=0 for 5 cycles in DONE, with in_valid=1 throughout → out_data stable, in_ready=0, no second acceptance; out_ready=1 → out_valid drops next edge and the pending request is accepted the cycle after.
- Reset mid-operation: rst=1 in RUN cycle 4 → next edge gives in_ready=1, busy=0, out_valid=0, tk_idx=0; a fresh op then completes with correct result and latency.
- Back-to-back: out_ready tied 1, in_valid tied 1 → one result every N_ROUNDS/UNROLL+2 cycles, with alternating in_inv honoured per op.
